dma_stream_loopback: RTL and testbench
======================================

# dma_stream_loopback

Parametrised AXI4-Stream loopback buffer for DMA channel testing: accepts a stream from a DMA MM2S channel, buffers it in an internal single-clock FIFO and returns it on an S2MM-facing stream. It generalises the earlier fixed-width, fixed-threshold tester with the following additions:

- Configurable width, depth and release threshold.
- A store-and-forward packet mode.
- Selectable tdest source.
- Optional traffic statistics.

## Interface
Parameters:
- ID, 4'h0, tdest value driven when DEST_MODE=0
- DW, 32, data width in bits; multiple of 8, 8..512
- DEPTH, 1024, FIFO entries; power of two, 4..8192
- THRESHOLD, 16, cut-through release level in entries; 1..DEPTH
- MODE, 0, 0 = cut-through, 1 = store-and-forward
- DEST_MODE, 0, 0 = output tdest is constant ID, 1 = input tdest stored per beat and passed through

Ports:
- tester_clk  in  1  clock
- tester_resetn  in  1  asynchronous active-low reset
- tester_i_tvalid  in  1  input beat valid
- tester_i_tready  out  1  input ready
- tester_i_tdata  in  DW  input data
- tester_i_tkeep  in  DW/8  input byte enables
- tester_i_tdest  in  4  input destination
- tester_i_tlast  in  1  input end of packet
- tester_o_tvalid  out  1  output beat valid
- tester_o_tready  in  1  output ready
- tester_o_tdata  out  DW  output data
- tester_o_tkeep  out  DW/8  output byte enables
- tester_o_tdest  out  4  output destination
- tester_o_tlast  out  1  output end of packet
- tester_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- tester_stat_clear  in  1  synchronous clear of statistics
- tester_stat_pkts  out  32  packets sent
- tester_stat_bytes  out  32  bytes sent

## Operation
- FIFO entry: {tlast, tkeep, tdata} and, when DEST_MODE=1, tdest.
  - Write beat: i_tvalid & i_tready.
  - Read beat: o_tvalid & o_tready.
- Storage: register-array memory with head-of-FIFO output (first-word fall-through). Output data, keep, last and dest come combinationally from the entry at the read pointer.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level = write count minus read count, range 0..DEPTH; a simultaneous write and read leaves it unchanged.
- i_tready = (level != DEPTH). Beats presented while not ready are not accepted and are not lost; normal AXIS backpressure applies.
- pkt_cnt counts complete packets in the FIFO:
  - +1 on a write beat with tlast.
  - −1 on a read beat with tlast.
  - Unchanged when both occur in the same cycle.
- Release gate `open` (register):
  - MODE 0: set when level ≥ THRESHOLD or pkt_cnt > 0.
  - MODE 1: set when pkt_cnt > 0, or when level == DEPTH (oversize-packet escape, prevents deadlock).
  - In both modes, once set, open stays set until a tlast read beat. It then re-evaluates the set condition using next-cycle values, so back-to-back packets stream without a bubble.
- o_tvalid = open & (level != 0).
  - Once asserted, o_tvalid must not drop before the beat is taken.
  - Data must stay stable under o_tready low.
- o_tdest: registered ID when DEST_MODE=0; stored tdest when DEST_MODE=1.

## Timing
- Reset values:
  - i_tready 0, o_tvalid 0, level 0, pkt_cnt 0, open 0, stats 0.
  - o_tdest: ID for DEST_MODE=0; 0 for DEST_MODE=1.
- Reset release: i_tready rises on the first tester_clk edge after release.
- Latency: a write at edge N is visible in level after edge N. open sets at edge N+1, so the earliest o_tvalid is after edge N+1 (cut-through, THRESHOLD=1).
- Full: i_tready drops in the cycle after the write that fills the FIFO. Any read in a cycle re-asserts i_tready after that edge.
- Empty while open: o_tvalid low, and open is held until tlast.
- Reset asserted mid-packet: all state clears asynchronously and buffered beats are discarded.

## Configuration
- DMA_LOOPBACK_STATS_EN defined:
  - stat_pkts increments on each tlast read beat.
  - stat_bytes adds popcount(o_tkeep) on each read beat.
  - Both wrap modulo 2^32. tester_stat_clear zeroes both, with priority over increment in the same cycle.
- Undefined: stat ports exist but are tied to 0, tester_stat_clear is ignored, and no counter logic is built.

## Test plan
- MODE 0, THRESHOLD 16, DW 32: write 20-beat packet 0x00..0x13 with o_tready=1 → o_tvalid rises 1 cycle after the 16th write; 20 beats out in order; tlast on 0x13.
- MODE 0: 3-beat packet (below threshold) → released after tlast write; o_tlast on beat 3; level returns to 0.
- MODE 1, DEPTH 16: send 40-beat packet → output stalls until level 16, escape opens gate, all 40 beats emerge in order with no loss.
- Hold o_tready=0 with DEPTH 16: push 18 beats → i_tready low after the 16th, level=16; release o_tready → remaining 2 beats accepted, data intact across pointer wrap.
- DEST_MODE=1: packets with tdest 3 then 9, back to back → o_tdest 3 then 9 per beat; no idle cycle between packets.
- STATS_EN: two packets, 4 beats tkeep 4'hF plus last tkeep 4'h3 → stat_pkts=2, stat_bytes=2×(16+2)=36; clear pulse → both 0. Assert tester_resetn low mid-packet → all outputs at reset values.

Source files
------------

// File: rtl/dma_stream_loopback.sv
// AXI4-Stream loopback buffer: a first-word-fall-through FIFO with a cut-through or store-and-forward release gate.
// Optional traffic statistics are built only when DMA_LOOPBACK_STATS_EN is defined.
module dma_stream_loopback #(
    parameter logic [3:0] ID        = 4'h0,
    parameter int         DW        = 32,
    parameter int         DEPTH     = 1024,
    parameter int         THRESHOLD = 16,
    parameter int         MODE      = 0,
    parameter int         DEST_MODE = 0
) (
    input  logic                       tester_clk,
    input  logic                       tester_resetn,
    input  logic                       tester_i_tvalid,
    output logic                       tester_i_tready,
    input  logic [DW-1:0]              tester_i_tdata,
    input  logic [DW/8-1:0]            tester_i_tkeep,
    input  logic [3:0]                 tester_i_tdest,
    input  logic                       tester_i_tlast,
    output logic                       tester_o_tvalid,
    input  logic                       tester_o_tready,
    output logic [DW-1:0]              tester_o_tdata,
    output logic [DW/8-1:0]            tester_o_tkeep,
    output logic [3:0]                 tester_o_tdest,
    output logic                       tester_o_tlast,
    output logic [$clog2(DEPTH):0]     tester_level,
    input  logic                       tester_stat_clear,
    output logic [31:0]                tester_stat_pkts,
    output logic [31:0]                tester_stat_bytes
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int KW = DW / 8;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] THR_LVL  = LW'(THRESHOLD);

    logic [DW-1:0] mem_data [DEPTH];
    logic [KW-1:0] mem_keep [DEPTH];
    logic          mem_last [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_nxt, pkt_cnt, pkt_cnt_nxt;
    logic          in_ready, open_q, open_nxt, wr_en, rd_en;

    // Gate set condition; the full-FIFO escape keeps oversize packets from deadlocking store-and-forward.
    function automatic logic gate_cond(input logic [LW-1:0] lvl, input logic [LW-1:0] pkts);
        if (MODE == 0) return (lvl >= THR_LVL) || (pkts != '0);
        else           return (pkts != '0) || (lvl == FULL_LVL);
    endfunction

    assign wr_en           = tester_i_tvalid & in_ready;
    assign rd_en           = tester_o_tvalid & tester_o_tready;
    assign tester_i_tready = in_ready;
    assign tester_o_tvalid = open_q & (level != '0);
    assign tester_o_tdata  = mem_data[rd_ptr];
    assign tester_o_tkeep  = mem_keep[rd_ptr];
    assign tester_o_tlast  = mem_last[rd_ptr];
    assign tester_level    = level;

    always_comb begin
        level_nxt   = level + LW'(wr_en) - LW'(rd_en);
        pkt_cnt_nxt = pkt_cnt + LW'(wr_en & tester_i_tlast) - LW'(rd_en & tester_o_tlast);
        open_nxt    = open_q;
        if (!open_q)
            open_nxt = gate_cond(level, pkt_cnt);
        else if (rd_en && tester_o_tlast)
            open_nxt = gate_cond(level_nxt, pkt_cnt_nxt);
    end

    always_ff @(posedge tester_clk or negedge tester_resetn) begin
        if (!tester_resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pkt_cnt  <= '0;
            open_q   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level    <= level_nxt;
            pkt_cnt  <= pkt_cnt_nxt;
            open_q   <= open_nxt;
            in_ready <= (level_nxt != FULL_LVL);
        end
    end

    always_ff @(posedge tester_clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= tester_i_tdata;
            mem_keep[wr_ptr] <= tester_i_tkeep;
            mem_last[wr_ptr] <= tester_i_tlast;
        end
    end

    generate
        if (DEST_MODE == 1) begin : g_dest_store
            logic [3:0] mem_dest [DEPTH];
            always_ff @(posedge tester_clk) begin
                if (wr_en) mem_dest[wr_ptr] <= tester_i_tdest;
            end
            // Forced to 0 while empty so the reset value is defined without clearing the array.
            assign tester_o_tdest = (level != '0) ? mem_dest[rd_ptr] : 4'h0;
        end else begin : g_dest_const
            logic [3:0] dest_q;
            logic       unused_tdest;
            always_ff @(posedge tester_clk or negedge tester_resetn) begin
                if (!tester_resetn) dest_q <= ID;
                else                dest_q <= ID;
            end
            assign tester_o_tdest = dest_q;
            assign unused_tdest   = ^tester_i_tdest;
        end
    endgenerate

`ifdef DMA_LOOPBACK_STATS_EN
    function automatic logic [31:0] popcount(input logic [KW-1:0] k);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < KW; i++) c = c + 32'(k[i]);
        return c;
    endfunction

    always_ff @(posedge tester_clk or negedge tester_resetn) begin
        if (!tester_resetn) begin
            tester_stat_pkts  <= '0;
            tester_stat_bytes <= '0;
        end else if (tester_stat_clear) begin
            tester_stat_pkts  <= '0;
            tester_stat_bytes <= '0;
        end else if (rd_en) begin
            if (tester_o_tlast) tester_stat_pkts <= tester_stat_pkts + 32'd1;
            tester_stat_bytes <= tester_stat_bytes + popcount(tester_o_tkeep);
        end
    end
`else
    logic unused_stat_clear;
    assign unused_stat_clear = tester_stat_clear;
    assign tester_stat_pkts  = '0;
    assign tester_stat_bytes = '0;
`endif

endmodule

// File: tb/tb_dma_stream_loopback.sv
// Directed/randomized bench: one cut-through instance (DEST_MODE=1) and one store-and-forward instance (DEPTH 16).
// A queue per instance holds accepted beats; each output beat is compared against the queue head.
module tb_dma_stream_loopback;

    localparam int         DW    = 32;
    localparam int         KW    = DW / 8;
    localparam logic [3:0] SF_ID = 4'hA;
`ifdef DMA_LOOPBACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [3:0]    dest;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic tester_clk = 1'b0;
    logic tester_resetn = 1'b0;
    always #5 tester_clk = ~tester_clk;

    logic          sel = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_keep = '0;
    logic [3:0]    in_dest = '0;
    logic          ct_o_ready = 1'b0, sf_o_ready = 1'b0, stat_clear = 1'b0;
    logic          ct_i_valid, sf_i_valid;

    logic          ct_i_tready, ct_o_tvalid, ct_o_tlast;
    logic [DW-1:0] ct_o_tdata;
    logic [KW-1:0] ct_o_tkeep;
    logic [3:0]    ct_o_tdest;
    logic [5:0]    ct_level;
    logic [31:0]   ct_stat_pkts, ct_stat_bytes;

    logic          sf_i_tready, sf_o_tvalid, sf_o_tlast;
    logic [DW-1:0] sf_o_tdata;
    logic [KW-1:0] sf_o_tkeep;
    logic [3:0]    sf_o_tdest;
    logic [4:0]    sf_level;
    logic [31:0]   sf_stat_pkts, sf_stat_bytes;

    assign ct_i_valid = in_valid & ~sel;
    assign sf_i_valid = in_valid & sel;

    dma_stream_loopback #(.ID(4'h0), .DW(DW), .DEPTH(32), .THRESHOLD(16), .MODE(0), .DEST_MODE(1)) u_ct (
        .tester_clk(tester_clk), .tester_resetn(tester_resetn),
        .tester_i_tvalid(ct_i_valid), .tester_i_tready(ct_i_tready), .tester_i_tdata(in_data),
        .tester_i_tkeep(in_keep), .tester_i_tdest(in_dest), .tester_i_tlast(in_last),
        .tester_o_tvalid(ct_o_tvalid), .tester_o_tready(ct_o_ready), .tester_o_tdata(ct_o_tdata),
        .tester_o_tkeep(ct_o_tkeep), .tester_o_tdest(ct_o_tdest), .tester_o_tlast(ct_o_tlast),
        .tester_level(ct_level), .tester_stat_clear(stat_clear),
        .tester_stat_pkts(ct_stat_pkts), .tester_stat_bytes(ct_stat_bytes)
    );

    dma_stream_loopback #(.ID(SF_ID), .DW(DW), .DEPTH(16), .THRESHOLD(16), .MODE(1), .DEST_MODE(0)) u_sf (
        .tester_clk(tester_clk), .tester_resetn(tester_resetn),
        .tester_i_tvalid(sf_i_valid), .tester_i_tready(sf_i_tready), .tester_i_tdata(in_data),
        .tester_i_tkeep(in_keep), .tester_i_tdest(in_dest), .tester_i_tlast(in_last),
        .tester_o_tvalid(sf_o_tvalid), .tester_o_tready(sf_o_ready), .tester_o_tdata(sf_o_tdata),
        .tester_o_tkeep(sf_o_tkeep), .tester_o_tdest(sf_o_tdest), .tester_o_tlast(sf_o_tlast),
        .tester_level(sf_level), .tester_stat_clear(stat_clear),
        .tester_stat_pkts(sf_stat_pkts), .tester_stat_bytes(sf_stat_bytes)
    );

    beat_t ct_q[$];
    beat_t sf_q[$];
    int    num_asserts = 0;
    int    num_fails = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_asserts++;
        assert (observed === expected) else begin
            num_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge tester_clk);
        #1;
    endtask

    // Presents one beat to the selected instance and holds it until the handshake completes.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic [3:0] dst, input logic l);
        logic  accepted = 1'b0;
        logic  rdy;
        int    n = 0;
        beat_t b;
        in_valid = 1'b1; in_data = d; in_keep = k; in_dest = dst; in_last = l;
        while (!accepted && n < 200) begin
            rdy = sel ? sf_i_tready : ct_i_tready;
            tick();
            accepted = rdy;
            n++;
        end
        in_valid = 1'b0;
        checkOutput("input_accepted", 64'(accepted), 64'd1);
        if (accepted) begin
            b.last = l; b.dest = dst; b.keep = k; b.data = d;
            if (sel) sf_q.push_back(b);
            else     ct_q.push_back(b);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sel ? 32'(sf_level) : 32'(ct_level)) != 0 && n < 300) begin
            tick();
            n++;
        end
        checkOutput("drain_level", sel ? 64'(sf_level) : 64'(ct_level), 64'd0);
        checkOutput("drain_queue", sel ? 64'(sf_q.size()) : 64'(ct_q.size()), 64'd0);
    endtask

    always @(negedge tester_clk) begin
        beat_t e;
        if (tester_resetn && ct_o_tvalid && ct_o_ready) begin
            checkOutput("ct_beat_expected", 64'(ct_q.size() != 0), 64'd1);
            if (ct_q.size() != 0) begin
                e = ct_q.pop_front();
                checkOutput("ct_data", 64'(ct_o_tdata), 64'(e.data));
                checkOutput("ct_keep", 64'(ct_o_tkeep), 64'(e.keep));
                checkOutput("ct_last", 64'(ct_o_tlast), 64'(e.last));
                checkOutput("ct_dest", 64'(ct_o_tdest), 64'(e.dest));
            end
        end
    end

    always @(negedge tester_clk) begin
        beat_t e;
        if (tester_resetn && sf_o_tvalid && sf_o_ready) begin
            checkOutput("sf_beat_expected", 64'(sf_q.size() != 0), 64'd1);
            if (sf_q.size() != 0) begin
                e = sf_q.pop_front();
                checkOutput("sf_data", 64'(sf_o_tdata), 64'(e.data));
                checkOutput("sf_keep", 64'(sf_o_tkeep), 64'(e.keep));
                checkOutput("sf_last", 64'(sf_o_tlast), 64'(e.last));
                checkOutput("sf_dest", 64'(sf_o_tdest), 64'(SF_ID));
            end
        end
    end

    initial begin
        beat_t first;

        repeat (3) tick();
        checkOutput("rst_ct_tready", 64'(ct_i_tready), 64'd0);
        checkOutput("rst_ct_tvalid", 64'(ct_o_tvalid), 64'd0);
        checkOutput("rst_ct_level", 64'(ct_level), 64'd0);
        checkOutput("rst_ct_tdest", 64'(ct_o_tdest), 64'd0);
        checkOutput("rst_sf_tdest", 64'(sf_o_tdest), 64'(SF_ID));
        checkOutput("rst_stat_pkts", 64'(ct_stat_pkts), 64'd0);
        checkOutput("rst_stat_bytes", 64'(ct_stat_bytes), 64'd0);
        tester_resetn = 1'b1;
        checkOutput("release_tready_low", 64'(ct_i_tready), 64'd0);
        tick();
        checkOutput("release_ct_tready", 64'(ct_i_tready), 64'd1);
        checkOutput("release_sf_tready", 64'(sf_i_tready), 64'd1);

        // Cut-through: gate opens one edge after the 16th write.
        sel = 1'b0; ct_o_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(DW'(i), 4'hF, 4'h2, i == 19);
            checkOutput("ct_threshold_valid", 64'(ct_o_tvalid), 64'(i >= 16));
        end
        waitDrain();
        checkOutput("ct_closed", 64'(ct_o_tvalid), 64'd0);

        // Short packet below threshold is released by its tlast.
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom, 4'hF, 4'($urandom), i == 2);
            checkOutput("short_hold", 64'(ct_o_tvalid), 64'd0);
        end
        tick();
        checkOutput("short_release", 64'(ct_o_tvalid), 64'd1);
        waitDrain();

        // Two buffered packets with different tdest drain without a bubble.
        ct_o_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus($urandom, 4'($urandom), 4'h3, i == 2);
        for (int i = 0; i < 2; i++) applyStimulus($urandom, 4'($urandom), 4'h9, i == 1);
        tick();
        ct_o_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge tester_clk);
            checkOutput("b2b_valid", 64'(ct_o_tvalid), 64'd1);
            checkOutput("b2b_dest", 64'(ct_o_tdest), (i < 3) ? 64'h3 : 64'h9);
            tick();
        end
        waitDrain();

        // Statistics: earlier traffic makes the clear observable.
        stat_clear = 1'b1; tick(); stat_clear = 1'b0;
        checkOutput("stat_clear_pkts", 64'(ct_stat_pkts), 64'd0);
        checkOutput("stat_clear_bytes", 64'(ct_stat_bytes), 64'd0);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 5; i++)
                applyStimulus($urandom, (i == 4) ? 4'h3 : 4'hF, 4'h1, i == 4);
        waitDrain();
        checkOutput("stat_pkts", 64'(ct_stat_pkts), STATS ? 64'd2 : 64'd0);
        checkOutput("stat_bytes", 64'(ct_stat_bytes), STATS ? 64'd36 : 64'd0);
        stat_clear = 1'b1; tick(); stat_clear = 1'b0;
        checkOutput("stat_reclear_pkts", 64'(ct_stat_pkts), 64'd0);
        checkOutput("stat_reclear_bytes", 64'(ct_stat_bytes), 64'd0);

        // Store-and-forward oversize packet escapes through the full-FIFO condition.
        sel = 1'b1; sf_o_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom, 4'hF, 4'($urandom), i == 39);
            if (i < 16) checkOutput("sf_store_hold", 64'(sf_o_tvalid), 64'd0);
            if (i == 15) begin
                checkOutput("sf_full_tready", 64'(sf_i_tready), 64'd0);
                checkOutput("sf_full_level", 64'(sf_level), 64'd16);
            end
        end
        waitDrain();

        // Backpressure across the pointer wrap.
        sf_o_ready = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus($urandom, 4'($urandom), 4'h0, 1'b0);
        checkOutput("bp_tready_low", 64'(sf_i_tready), 64'd0);
        checkOutput("bp_level_full", 64'(sf_level), 64'd16);
        tick();
        checkOutput("bp_escape_valid", 64'(sf_o_tvalid), 64'd1);
        first = sf_q[0];
        repeat (3) tick();
        checkOutput("bp_valid_held", 64'(sf_o_tvalid), 64'd1);
        checkOutput("bp_data_stable", 64'(sf_o_tdata), 64'(first.data));
        checkOutput("bp_level_held", 64'(sf_level), 64'd16);
        sf_o_ready = 1'b1;
        applyStimulus($urandom, 4'hF, 4'h0, 1'b0);
        applyStimulus($urandom, 4'hF, 4'h0, 1'b1);
        waitDrain();

        // Reset in the middle of a packet discards everything buffered.
        sel = 1'b0; ct_o_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus($urandom, 4'hF, 4'h5, 1'b0);
        #2 tester_resetn = 1'b0;
        #1;
        checkOutput("mid_rst_tready", 64'(ct_i_tready), 64'd0);
        checkOutput("mid_rst_tvalid", 64'(ct_o_tvalid), 64'd0);
        checkOutput("mid_rst_level", 64'(ct_level), 64'd0);
        checkOutput("mid_rst_tdest", 64'(ct_o_tdest), 64'd0);
        checkOutput("mid_rst_sf_tdest", 64'(sf_o_tdest), 64'(SF_ID));
        checkOutput("mid_rst_stat_pkts", 64'(ct_stat_pkts), 64'd0);
        ct_q.delete();
        sf_q.delete();
        tick();
        tester_resetn = 1'b1;
        tick(); tick();
        ct_o_ready = 1'b1;
        applyStimulus($urandom, 4'h7, 4'h6, 1'b1);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
        $finish;
    end

endmodule
